// File: rtl/numa_pkg.sv
// Shared definitions for the NUMA crossbar and its bank-side endpoints.
//
// Contents:
//   idx_width()      - master-index width for a given number of masters (at least 1)
//   be_width()       - byte-enable width for a given data width
//   Def*             - default geometry used by the crossbar and the bank responders
//   numa_bank_req_t  - packed request payload {we, be, addr, data}. The crossbar-side
//                      producer builds wdata from it, and the responder unpacks it
//                      with the same field order.
package numa_pkg;

  function automatic int unsigned idx_width(input int unsigned num_in);
    return (num_in > 1) ? $clog2(num_in) : 1;
  endfunction

  function automatic int unsigned be_width(input int unsigned data_width);
    return data_width / 8;
  endfunction

  localparam int unsigned DefNumIn     = 4;
  localparam int unsigned DefDataWidth = 32;
  localparam int unsigned DefAddrWidth = 10;
  localparam int unsigned DefIdxWidth  = idx_width(DefNumIn);
  localparam int unsigned DefBeWidth   = be_width(DefDataWidth);

  typedef struct packed {
    logic                    we;
    logic [DefBeWidth-1:0]   be;
    logic [DefAddrWidth-1:0] addr;
    logic [DefDataWidth-1:0] data;
  } numa_bank_req_t;

endpackage

// File: rtl/numa_resp_fifo.sv
// Fall-through response FIFO with a generic entry type.
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   push_i, data_i  write strobe and entry
//   full_o          all Depth entries occupied
//   pop_i           consume the head entry (only while !empty_o)
//   data_o          head entry. While storage is empty, a push is bypassed straight
//                   through so it is visible in the same cycle. Otherwise the value is zero.
//   empty_o         nothing to present (storage empty and no push this cycle)
module numa_resp_fifo #(
  parameter int unsigned Depth = 2,
  parameter type entry_t = logic
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   push_i,
  input  entry_t data_i,
  output logic   full_o,
  input  logic   pop_i,
  output entry_t data_o,
  output logic   empty_o
);

  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntWidth = $clog2(Depth + 1);

  typedef logic [PtrWidth-1:0] ptr_t;
  localparam ptr_t LastPtr = ptr_t'(Depth - 1);

  entry_t              mem_q [Depth];
  ptr_t                rptr_q;
  ptr_t                wptr_q;
  logic [CntWidth-1:0] cnt_q;
  logic                stored_empty;
  logic                write_en;
  logic                read_en;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic ptr_t next_ptr(input ptr_t p);
    return (p == LastPtr) ? '0 : p + ptr_t'(1);
  endfunction

  assign stored_empty = (cnt_q == '0);
  assign full_o       = (cnt_q == CntWidth'(Depth));
  assign empty_o      = stored_empty && !push_i;

  // A push into empty storage that is popped in the same cycle only passes through.
  assign write_en = push_i && !(stored_empty && pop_i);
  assign read_en  = pop_i && !stored_empty;

  always_comb begin
    data_o = '0;
    if (!stored_empty) begin
      data_o = mem_q[rptr_q];
    end else if (push_i) begin
      data_o = data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (write_en) begin
      mem_q[wptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (write_en) begin
        wptr_q <= next_ptr(wptr_q);
      end
      if (read_en) begin
        rptr_q <= next_ptr(rptr_q);
      end
      if (write_en && !read_en) begin
        cnt_q <= cnt_q + CntWidth'(1);
      end else if (read_en && !write_en) begin
        cnt_q <= cnt_q - CntWidth'(1);
      end
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(push_i && full_o));
      assert (!(pop_i && empty_o));
      assert (Depth >= 1);
    end
  end
`endif

endmodule

// File: rtl/numa_bank_responder.sv
// Bank-side endpoint for one output port of the NUMA crossbar.
//
// Accepts crossbar requests by credit, drives a fixed-latency single-port SRAM bank,
// and returns responses in acceptance order under ready backpressure.
//
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   req_i, idx_i, gnt_o     request, requesting master, grant (combinational)
//   wdata_i                 packed {we, be, addr, data} payload
//   vld_o, rdy_i            response valid / ready handshake
//   idx_o, rdata_o          response destination master and data (zero for writes)
//   mem_req_o .. mem_wdata_o  bank access, driven in the accepting cycle
//   mem_rdata_i             bank read data, valid MemLatency cycles after mem_req_o
module numa_bank_responder
  import numa_pkg::*;
#(
  parameter int unsigned NumIn      = 4,
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned AddrWidth  = 10,
  parameter int unsigned MemLatency = 1,
  parameter int unsigned RespDepth  = 2,
  localparam int unsigned IdxWidth  = idx_width(NumIn),
  localparam int unsigned BeWidth   = be_width(DataWidth),
  localparam int unsigned ReqWidth  = 1 + BeWidth + AddrWidth + DataWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_i,
  input  logic [IdxWidth-1:0]  idx_i,
  output logic                 gnt_o,
  input  logic [ReqWidth-1:0]  wdata_i,
  output logic                 vld_o,
  input  logic                 rdy_i,
  output logic [IdxWidth-1:0]  idx_o,
  output logic [DataWidth-1:0] rdata_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [BeWidth-1:0]   mem_be_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [DataWidth-1:0] mem_wdata_o,
  input  logic [DataWidth-1:0] mem_rdata_i
);

  localparam int unsigned CntWidth = $clog2(RespDepth + 1);

  typedef struct packed {
    logic                valid;
    logic [IdxWidth-1:0] idx;
    logic                we;
  } tag_t;

  typedef struct packed {
    logic [IdxWidth-1:0]  idx;
    logic [DataWidth-1:0] rdata;
  } resp_t;

  logic                 req_we;
  logic [BeWidth-1:0]   req_be;
  logic [AddrWidth-1:0] req_addr;
  logic [DataWidth-1:0] req_data;

  logic [CntWidth-1:0]  cnt_q;
  logic [CntWidth-1:0]  cnt_d;
  logic                 accept;
  logic                 pop;

  tag_t                 tag_q [MemLatency];
  tag_t                 tag_out;
  resp_t                push_data;
  resp_t                head;
  logic                 fifo_push;
  logic                 fifo_full;
  logic                 fifo_empty;

  // Field order matches numa_bank_req_t.
  assign {req_we, req_be, req_addr, req_data} = wdata_i;

  // The credit count covers both in-flight bank accesses and buffered responses.
  // Granting only while it is below RespDepth means every access already has a
  // FIFO slot reserved. This keeps rdy_i out of the grant path and lets the tag
  // pipeline run without stalls.
  assign gnt_o  = req_i && (cnt_q < CntWidth'(RespDepth));
  assign accept = req_i && gnt_o;

  assign mem_req_o   = accept;
  assign mem_we_o    = req_we;
  assign mem_be_o    = req_be;
  assign mem_addr_o  = req_addr;
  assign mem_wdata_o = req_data;

  always_comb begin
    cnt_d = cnt_q;
    if (accept && !pop) begin
      cnt_d = cnt_q + CntWidth'(1);
    end else if (pop && !accept) begin
      cnt_d = cnt_q - CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The tag for each access travels alongside the bank's own latency. The last
  // stage lines up with the cycle in which mem_rdata_i is valid for that access.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MemLatency; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= '{valid: accept, idx: idx_i, we: req_we};
      for (int i = 1; i < MemLatency; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign tag_out   = tag_q[MemLatency-1];
  assign fifo_push = tag_out.valid;

  always_comb begin
    push_data       = '0;
    push_data.idx   = tag_out.idx;
    push_data.rdata = tag_out.we ? '0 : mem_rdata_i;
  end

  numa_resp_fifo #(
    .Depth   (RespDepth),
    .entry_t (resp_t)
  ) u_resp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .data_i  (push_data),
    .full_o  (fifo_full),
    .pop_i   (pop),
    .data_o  (head),
    .empty_o (fifo_empty)
  );

  assign vld_o   = !fifo_empty;
  assign idx_o   = head.idx;
  assign rdata_o = head.rdata;
  assign pop     = vld_o && rdy_i;

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (rst_ni) begin
      assert (cnt_q <= CntWidth'(RespDepth));
      assert (!(fifo_push && fifo_full));
      assert (MemLatency >= 1);
      assert (RespDepth >= 1);
      assert (NumIn >= 1);
      assert ((DataWidth % 8) == 0 && DataWidth >= 8);
    end
  end
`endif

endmodule
